// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit, then shifts one
// odd-parity command byte out on device clock falls and reports ack, no-ack or timeout.
module ps2_host_tx #(
    parameter int CLK_KHZ    = 6500,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clkps2_in,
    input  logic       dataps2_in,
    output logic       clkps2_oe,
    output logic       dataps2_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_ack,
    output logic       tx_error
);

    localparam int          INH_CYC  = INHIBIT_US * CLK_KHZ / 1000;
    localparam int          TO_CYC   = TIMEOUT_MS * CLK_KHZ;
    localparam logic [19:0] INH_LAST = 20'(INH_CYC - 1);
    localparam logic [19:0] TO_LIM   = 20'(TO_CYC);
    localparam logic [19:0] SETUP_LAST = 20'd7;

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_START, S_SEND, S_ACK, S_WAIT_IDLE
    } state_t;

    logic       clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic       clk_filt_q, fall_q;
    logic [1:0] flt_cnt_q;

    state_t      state_q;
    logic [19:0] cnt_q;
    logic [9:0]  shift_q;
    logic [3:0]  bit_cnt_q;
    logic        clk_oe_q, dat_oe_q, busy_q, done_q, ack_q, err_q;

    logic [19:0] cnt_inc_d;
    logic        timeout_d;
    logic        in_frame_d;
    logic        accept_d;

    // Synchronisers reset to the idle-high line level so release never looks like an edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_filt_q <= 1'b1;
            flt_cnt_q  <= 2'd0;
            fall_q     <= 1'b0;
        end else begin
            clk_s1_q <= clkps2_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= dataps2_in;
            dat_s2_q <= dat_s1_q;
            fall_q   <= 1'b0;
            if (clk_s2_q == clk_filt_q) begin
                flt_cnt_q <= 2'd0;
            end else if (flt_cnt_q == 2'd3) begin
                clk_filt_q <= clk_s2_q;
                flt_cnt_q  <= 2'd0;
                fall_q     <= ~clk_s2_q;
            end else begin
                flt_cnt_q <= flt_cnt_q + 2'd1;
            end
        end
    end

    assign cnt_inc_d  = (cnt_q == 20'hFFFFF) ? cnt_q : cnt_q + 20'd1;
    assign timeout_d  = (cnt_q >= TO_LIM);
    assign in_frame_d = (state_q == S_SEND) || (state_q == S_ACK) || (state_q == S_WAIT_IDLE);
    // A request landing on the tx_done cycle belongs to the finished frame and is dropped.
    assign accept_d   = tx_start && !busy_q && !done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= 20'd0;
            shift_q   <= 10'd0;
            bit_cnt_q <= 4'd0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (in_frame_d && !fall_q && timeout_d) begin
                clk_oe_q <= 1'b0;
                dat_oe_q <= 1'b0;
                err_q    <= 1'b1;
                ack_q    <= 1'b0;
                done_q   <= 1'b1;
                busy_q   <= 1'b0;
                state_q  <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        clk_oe_q <= 1'b0;
                        dat_oe_q <= 1'b0;
                        if (accept_d) begin
                            shift_q  <= {1'b1, ~^tx_data, tx_data};
                            busy_q   <= 1'b1;
                            err_q    <= 1'b0;
                            ack_q    <= 1'b0;
                            cnt_q    <= 20'd0;
                            clk_oe_q <= 1'b1;
                            state_q  <= S_INHIBIT;
                        end
                    end
                    S_INHIBIT: begin
                        if (cnt_q == INH_LAST) begin
                            dat_oe_q <= 1'b1;
                            cnt_q    <= 20'd0;
                            state_q  <= S_START;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    S_START: begin
                        if (cnt_q == SETUP_LAST) begin
                            clk_oe_q  <= 1'b0;
                            cnt_q     <= 20'd0;
                            bit_cnt_q <= 4'd0;
                            state_q   <= S_SEND;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    S_SEND: begin
                        if (fall_q) begin
                            dat_oe_q  <= ~shift_q[0];
                            shift_q   <= {1'b0, shift_q[9:1]};
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            cnt_q     <= 20'd0;
                            if (bit_cnt_q == 4'd9) begin
                                state_q <= S_ACK;
                            end
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    S_ACK: begin
                        if (fall_q) begin
                            ack_q   <= ~dat_s2_q;
                            cnt_q   <= 20'd0;
                            state_q <= S_WAIT_IDLE;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    S_WAIT_IDLE: begin
                        if (clk_filt_q && dat_s2_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else if (fall_q) begin
                            cnt_q <= 20'd0;
                        end else begin
                            cnt_q <= cnt_inc_d;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign clkps2_oe  = clk_oe_q;
    assign dataps2_oe = dat_oe_q;
    assign busy       = busy_q;
    assign tx_done    = done_q;
    assign tx_ack     = ack_q;
    assign tx_error   = err_q;

endmodule
